// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the programming-port loader: FSM state encoding,
//   error codes reported on err_code, and the default image size.
//   No ports (package).
package prog_loader_pkg;

  // Default image: 8 states x 3 bytes + 2 counter constants x 2 bytes.
  localparam int PROG_IMAGE_BYTES = 28;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    CHECK  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_CSUM         = 2'b01;
  localparam logic [1:0] ERR_ABORT_FILL   = 2'b10;
  localparam logic [1:0] ERR_ABORT_STREAM = 2'b11;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Byte-wide valid/ready channel from the host I/O front end to the loader.
//   Signals:
//     in_data  [DATA_W]  host byte
//     in_valid           host byte valid
//     in_ready           loader accepts a byte this cycle
//   Modports: master = host side, slave = loader side.
interface prog_loader_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/prog_byte_buf.sv
// prog_byte_buf
//   DEPTH x DATA_W register file holding one instruction image.
//   Ports:
//     clock              system clock
//     we, waddr, wdata   write port (one byte per clock)
//     raddr, rdata       combinational stream read port
//     rb_addr, rb_data   registered readback port, 1-cycle latency,
//                        out-of-range addresses return 0
//                        (present only with PROG_LOADER_READBACK_EN)
//   Contents are not reset; they are only meaningful after a fill.
module prog_byte_buf #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = $clog2(DEPTH + 1),
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef PROG_LOADER_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

`ifdef PROG_LOADER_READBACK_EN
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  always_ff @(posedge clock) begin
    rb_data <= (rb_addr < DEPTH_A) ? mem[rb_addr] : '0;
  end
`endif

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Host-side transmitter for the controller's programming port. Collects
//   IMAGE_BYTES image bytes plus one checksum byte from the host channel,
//   verifies that the modulo-256 sum of all of them is zero, then drives
//   prog_enable/prog_data as one unbroken burst, one byte per clock.
//   Ports:
//     clock, rst_n        clock, synchronous active-low reset
//     host (slave)        in_data/in_valid/in_ready host byte channel
//     abort               cancel the current load
//     prog_enable         to controller prog_enable
//     prog_data           to controller data_in (0 when prog_enable=0)
//     busy                high unless idle in FILL with no bytes taken
//     done                one-cycle pulse, image delivered
//     error               one-cycle pulse, checksum fail or abort
//     err_code            held until the next load starts
//     rb_addr, rb_data    buffer readback (only with PROG_LOADER_READBACK_EN)
//   Optional feature macro: PROG_LOADER_READBACK_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMAGE_BYTES = PROG_IMAGE_BYTES,
  parameter int ADDR_W      = $clog2(IMAGE_BYTES + 1),
  parameter int DATA_W      = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  prog_loader_if.slave      host,
  input  logic              abort,
  output logic              prog_enable,
  output logic [DATA_W-1:0] prog_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
`ifdef PROG_LOADER_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_BYTES - 1);
  localparam logic [ADDR_W-1:0] CSUM_IDX = ADDR_W'(IMAGE_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              prog_enable_q, prog_enable_d;
  logic [DATA_W-1:0] prog_data_q, prog_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              in_ready_q, in_ready_d;

  logic              accept;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;

  prog_byte_buf #(
    .DEPTH  (IMAGE_BYTES),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clock   (clock),
    .we      (buf_we),
    .waddr   (idx_q),
    .wdata   (host.in_data),
    .raddr   (idx_q),
    .rdata   (buf_rdata)
`ifdef PROG_LOADER_READBACK_EN
    ,
    .rb_addr (rb_addr),
    .rb_data (rb_data)
`endif
  );

  // A byte arriving together with abort is dropped.
  assign accept = host.in_valid && in_ready_q && !abort;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    err_code_d    = err_code_q;
    prog_enable_d = 1'b0;
    prog_data_d   = '0;
    done_d        = 1'b0;
    error_d       = 1'b0;
    buf_we        = 1'b0;

    unique case (state_q)
      FILL: begin
        if (abort) begin
          // Abort with nothing collected yet is a no-op.
          if (idx_q != '0) begin
            error_d    = 1'b1;
            err_code_d = ERR_ABORT_FILL;
            idx_d      = '0;
            sum_d      = '0;
          end
        end else if (accept) begin
          if (idx_q == '0) begin
            err_code_d = ERR_NONE;
          end
          sum_d = sum_q + host.in_data;
          idx_d = idx_q + ADDR_W'(1);
          // The trailing checksum byte only feeds the sum.
          if (idx_q == CSUM_IDX) begin
            state_d = CHECK;
          end else begin
            buf_we = 1'b1;
          end
        end
      end

      CHECK: begin
        idx_d = '0;
        sum_d = '0;
        if (abort) begin
          error_d    = 1'b1;
          err_code_d = ERR_ABORT_STREAM;
          state_d    = FILL;
        end else if (sum_q == '0) begin
          state_d = STREAM;
        end else begin
          error_d    = 1'b1;
          err_code_d = ERR_CSUM;
          state_d    = FILL;
        end
      end

      STREAM: begin
        if (abort) begin
          error_d    = 1'b1;
          err_code_d = ERR_ABORT_STREAM;
          state_d    = FILL;
          idx_d      = '0;
        end else begin
          prog_enable_d = 1'b1;
          prog_data_d   = buf_rdata;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      DONE: begin
        // The last byte is already on the pins; delivery is complete.
        done_d  = 1'b1;
        state_d = FILL;
        idx_d   = '0;
        sum_d   = '0;
      end

      default: begin
        state_d = FILL;
        idx_d   = '0;
        sum_d   = '0;
      end
    endcase

    in_ready_d = (state_d == FILL);
    busy_d     = !((state_d == FILL) && (idx_d == '0));
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q       <= FILL;
      idx_q         <= '0;
      sum_q         <= '0;
      err_code_q    <= ERR_NONE;
      prog_enable_q <= 1'b0;
      prog_data_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      err_code_q    <= err_code_d;
      prog_enable_q <= prog_enable_d;
      prog_data_q   <= prog_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign host.in_ready = in_ready_q;
  assign prog_enable   = prog_enable_q;
  assign prog_data     = prog_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int NB = 28;

  typedef logic [7:0] img_t [NB];

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic       prog_enable;
  logic [7:0] prog_data;
  logic       busy, done, error;
  logic [1:0] err_code;
`ifdef PROG_LOADER_READBACK_EN
  logic [4:0] rb_addr;
  logic [7:0] rb_data;
`endif

  prog_loader_if #(.DATA_W(8)) hif ();

  prog_loader dut (
    .clock       (clk),
    .rst_n       (rst_n),
    .host        (hif),
    .abort       (abort),
    .prog_enable (prog_enable),
    .prog_data   (prog_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
`ifdef PROG_LOADER_READBACK_EN
    ,
    .rb_addr     (rb_addr),
    .rb_data     (rb_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observation of the programming port
  logic [7:0] obs_q[$];
  int  pe_runs  = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;
  bit  pe_prev  = 1'b0;
  bit  mon_en   = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prog_enable) begin
        obs_q.push_back(prog_data);
        if (!pe_prev) pe_runs++;
      end else begin
        chk("pdata_idle", int'(prog_data), 0);
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
      pe_prev = prog_enable;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Checksum byte that makes the modulo-256 total zero
  function automatic logic [7:0] good_csum(input img_t img);
    int s = 0;
    for (int i = 0; i < NB; i++) s += int'(img[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        hif.in_valid = 1'b0;
        tick();
      end
    end
    hif.in_data  = b;
    hif.in_valid = 1'b1;
    n = 0;
    while (!hif.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    tick();
    hif.in_valid = 1'b0;
  endtask

  task automatic send_image(input img_t img, input logic [7:0] cs, input bit gaps);
    for (int i = 0; i < NB; i++) send_byte(img[i], gaps);
    send_byte(cs, gaps);
  endtask

  // Full load with outcome predicted from the checksum rule
  task automatic run_load(input string tag, input img_t img, input logic [7:0] cs,
                          input bit gaps);
    int  d0, e0, r0, s;
    bit  good;
    d0 = done_cnt; e0 = err_cnt; r0 = pe_runs;
    obs_q.delete();
    send_image(img, cs, gaps);
    for (int c = 0; c < 200 && done_cnt == d0 && err_cnt == e0; c++) tick();
    if (done_cnt == d0 && err_cnt == e0) chk({tag, "_timeout"}, 0, 1);
    tick();
    tick();
    s = int'(cs);
    for (int i = 0; i < NB; i++) s += int'(img[i]);
    good = ((s % 256) == 0);
    if (good) begin
      chk({tag, "_len"}, obs_q.size(), NB);
      for (int i = 0; i < NB && i < obs_q.size(); i++)
        chk($sformatf("%s_byte%0d", tag, i), int'(obs_q[i]), int'(img[i]));
      chk({tag, "_runs"}, pe_runs - r0, 1);
      chk({tag, "_done"}, done_cnt - d0, 1);
      chk({tag, "_err"}, err_cnt - e0, 0);
      chk({tag, "_code"}, int'(err_code), 0);
    end else begin
      chk({tag, "_len"}, obs_q.size(), 0);
      chk({tag, "_done"}, done_cnt - d0, 0);
      chk({tag, "_err"}, err_cnt - e0, 1);
      chk({tag, "_code"}, int'(err_code), 1);
    end
    chk({tag, "_ready"}, int'(hif.in_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Send a good image and stop once k bytes have been seen on the port
  task automatic stream_until(input img_t img, input int k);
    int seen = 0;
    int c = 0;
    send_image(img, good_csum(img), 1'b0);
    while (seen < k && c < 100) begin
      if (prog_enable) seen++;
      if (seen < k) tick();
      c++;
    end
    if (seen < k) chk("stream_wait_timeout", seen, k);
  endtask

  img_t seq_img, rnd_img;
  int   d0, e0;

  initial begin
    rst_n        = 1'b0;
    abort        = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_data  = 8'h00;
`ifdef PROG_LOADER_READBACK_EN
    rb_addr = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", int'(hif.in_ready), 1);
    chk("rst_pe", int'(prog_enable), 0);
    chk("rst_pdata", int'(prog_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_code", int'(err_code), 0);
    mon_en = 1'b1;

    // Good image 0x01..0x1C, checksum 0x6A
    for (int i = 0; i < NB; i++) seq_img[i] = 8'(i + 1);
    chk("csum_model", int'(good_csum(seq_img)), 8'h6A);
    run_load("good", seq_img, 8'h6A, 1'b0);

    // Bad checksum
    run_load("badcs", seq_img, 8'h00, 1'b0);

    // Randomized images with gaps, occasionally corrupted checksums
    for (int t = 0; t < 6; t++) begin
      logic [7:0] cs;
      for (int i = 0; i < NB; i++) rnd_img[i] = 8'($urandom_range(0, 255));
      cs = good_csum(rnd_img);
      if (t % 3 == 2) cs = cs + 8'($urandom_range(1, 255));
      run_load($sformatf("rnd%0d", t), rnd_img, cs, 1'b1);
    end

    // Abort mid-stream at stream cycle 10
    for (int i = 0; i < NB; i++) rnd_img[i] = 8'($urandom_range(0, 255));
    d0 = done_cnt; e0 = err_cnt;
    obs_q.delete();
    stream_until(rnd_img, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abs_pe_drop", int'(prog_enable), 0);
    chk("abs_error", int'(error), 1);
    chk("abs_code", int'(err_code), 3);
    chk("abs_ready", int'(hif.in_ready), 1);
    tick();
    chk("abs_len", obs_q.size(), 10);
    for (int i = 0; i < 10 && i < obs_q.size(); i++)
      chk($sformatf("abs_byte%0d", i), int'(obs_q[i]), int'(rnd_img[i]));
    chk("abs_done", done_cnt - d0, 0);
    chk("abs_errcnt", err_cnt - e0, 1);
    run_load("after_abs", seq_img, good_csum(seq_img), 1'b0);

    // Abort while idle is ignored
    e0 = err_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle_abort_err", err_cnt - e0, 0);
    chk("idle_abort_code", int'(err_code), 0);

    // Abort in FILL after 5 bytes, with a byte offered in the same cycle
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    chk("fill_busy", int'(busy), 1);
    e0 = err_cnt;
    hif.in_data  = 8'hA5;
    hif.in_valid = 1'b1;
    abort        = 1'b1;
    tick();
    hif.in_valid = 1'b0;
    abort        = 1'b0;
    chk("abf_error", int'(error), 1);
    chk("abf_code", int'(err_code), 2);
    chk("abf_busy", int'(busy), 0);
    tick();
    chk("abf_errcnt", err_cnt - e0, 1);
    for (int i = 0; i < NB; i++) rnd_img[i] = 8'($urandom_range(0, 255));
    run_load("after_abf", rnd_img, good_csum(rnd_img), 1'b1);

    // Reset mid-stream at stream cycle 3
    for (int i = 0; i < NB; i++) rnd_img[i] = 8'($urandom_range(0, 255));
    d0 = done_cnt; e0 = err_cnt;
    stream_until(rnd_img, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstm_pe", int'(prog_enable), 0);
    chk("rstm_ready", int'(hif.in_ready), 1);
    chk("rstm_done", int'(done), 0);
    chk("rstm_error", int'(error), 0);
    chk("rstm_code", int'(err_code), 0);
    repeat (NB + 5) tick();
    chk("rstm_donecnt", done_cnt - d0, 0);
    chk("rstm_errcnt", err_cnt - e0, 0);
`ifdef PROG_LOADER_READBACK_EN
    rb_addr = 5'd0;
    tick();
    chk("rb_addr0", int'(rb_data), int'(rnd_img[0]));
    rb_addr = 5'd27;
    tick();
    chk("rb_addr27", int'(rb_data), int'(rnd_img[27]));
    rb_addr = 5'd28;
    tick();
    chk("rb_oob", int'(rb_data), 0);
`endif
    run_load("after_rst", seq_img, good_csum(seq_img), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
